// File: rtl/dma_priority_arbiter_pkg.sv
// Shared configuration for the DMA priority arbiter: channel count, FSM state
// type and the bit positions of the controller command register.
package dmaRegConfigPkg;

  localparam int CHANNELS = 4;
  localparam int IDX_W    = 2;

  localparam int CMD_DISABLE_BIT  = 2;
  localparam int CMD_ROTATE_BIT   = 4;
  localparam int CMD_DREQ_LOW_BIT = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    SERVICE   = 2'd2
  } arbState_e;

  function automatic logic [CHANNELS-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [CHANNELS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_encoder.sv
// Combinational winner select: fixed (channel 0 highest) or rotating, where the
// search starts one past lowPtr and wraps around the channel ring.
module dma_priority_encoder #(
  parameter int CHANNELS = dmaRegConfigPkg::CHANNELS
) (
  input  logic [CHANNELS-1:0]              req_i,
  input  logic [dmaRegConfigPkg::IDX_W-1:0] lowPtr_i,
  input  logic                             rotateEn_i,
  output logic                             valid_o,
  output logic [dmaRegConfigPkg::IDX_W-1:0] index_o
);
  import dmaRegConfigPkg::*;

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand    = '0;
    start   = rotateEn_i ? (lowPtr_i + IDX_W'(1)) : '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: picks a requesting channel, requests the bus from the CPU
// with HRQ and acknowledges the winner with a one-hot DACK once HLDA arrives.
module dma_priority_arbiter #(
  parameter int CHANNELS = dmaRegConfigPkg::CHANNELS
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [CHANNELS-1:0]              dreq_i,
  input  logic                             hlda_i,
  input  logic [7:0]                       commandReg_i,
  input  logic [CHANNELS-1:0]              channelMask_i,
  input  logic                             serviceDone_i,
  input  logic                             intEop_i,
  output logic                             hrq_o,
  output logic [CHANNELS-1:0]              dack_o,
  output logic [dmaRegConfigPkg::IDX_W-1:0] activeChannel_o,
  output logic                             channelActive_o
);
  import dmaRegConfigPkg::*;

  arbState_e           state_q;
  logic                hrq_q;
  logic [CHANNELS-1:0] dack_q;
  logic [IDX_W-1:0]    activeChannel_q;
  logic                channelActive_q;
  logic [IDX_W-1:0]    lowPtr_q;
  logic                latchedPol_q;
  logic                latchedRot_q;

  logic [CHANNELS-1:0] effReq;
  logic                winValid;
  logic [IDX_W-1:0]    winIdx;
  logic                ownerReqLive;
  logic                completion;

  assign effReq = (dreq_i ^ {CHANNELS{commandReg_i[CMD_DREQ_LOW_BIT]}}) & ~channelMask_i;

  // Once granted, only the latched polarity matters so register changes cannot disturb the grant.
  assign ownerReqLive = dreq_i[activeChannel_q] ^ latchedPol_q;
  assign completion   = serviceDone_i | intEop_i;

  dma_priority_encoder #(.CHANNELS(CHANNELS)) uEncoder (
    .req_i      (effReq),
    .lowPtr_i   (lowPtr_q),
    .rotateEn_i (commandReg_i[CMD_ROTATE_BIT]),
    .valid_o    (winValid),
    .index_o    (winIdx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      hrq_q           <= 1'b0;
      dack_q          <= '0;
      activeChannel_q <= '0;
      channelActive_q <= 1'b0;
      lowPtr_q        <= IDX_W'(CHANNELS - 1);
      latchedPol_q    <= 1'b0;
      latchedRot_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!commandReg_i[CMD_DISABLE_BIT] && winValid) begin
            state_q         <= WAIT_HLDA;
            hrq_q           <= 1'b1;
            activeChannel_q <= winIdx;
            latchedPol_q    <= commandReg_i[CMD_DREQ_LOW_BIT];
            latchedRot_q    <= commandReg_i[CMD_ROTATE_BIT];
          end
        end
        WAIT_HLDA: begin
          if (hlda_i) begin
            state_q         <= SERVICE;
            dack_q          <= oneHot(activeChannel_q);
            channelActive_q <= 1'b1;
          end else if (!ownerReqLive) begin
            state_q <= IDLE;
            hrq_q   <= 1'b0;
          end
        end
        SERVICE: begin
          // Losing the bus aborts without rotating; a real completion rotates once.
          if (!hlda_i || completion) begin
            state_q         <= IDLE;
            hrq_q           <= 1'b0;
            dack_q          <= '0;
            channelActive_q <= 1'b0;
            if (hlda_i && latchedRot_q) begin
              lowPtr_q <= activeChannel_q;
            end
          end
        end
        default: begin
          state_q         <= IDLE;
          hrq_q           <= 1'b0;
          dack_q          <= '0;
          channelActive_q <= 1'b0;
        end
      endcase
    end
  end

  assign hrq_o           = hrq_q;
  assign dack_o          = dack_q;
  assign activeChannel_o = activeChannel_q;
  assign channelActive_o = channelActive_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_dma_priority_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] dreq;
  logic       hlda;
  logic [7:0] commandReg;
  logic [3:0] channelMask;
  logic       serviceDone;
  logic       intEop;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] activeChannel;
  logic       channelActive;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus request, whether the CPU granted it, and the rotation pointer.
  int mOwner;
  bit mHeld;
  int mLowPtr;
  int mAct;
  bit mPol;
  bit mRot;

  dma_priority_arbiter #(.CHANNELS(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .dreq_i          (dreq),
    .hlda_i          (hlda),
    .commandReg_i    (commandReg),
    .channelMask_i   (channelMask),
    .serviceDone_i   (serviceDone),
    .intEop_i        (intEop),
    .hrq_o           (hrq),
    .dack_o          (dack),
    .activeChannel_o (activeChannel),
    .channelActive_o (channelActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pickWinner(input logic [3:0] eff, input bit rot, input int lp);
    int ch;
    for (int k = 0; k < 4; k++) begin
      ch = rot ? (lp + 1 + k) % 4 : k;
      if (eff[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic modelStep(input bit r, input logic [3:0] dq, input bit hl, input logic [7:0] cmd,
                           input logic [3:0] msk, input bit dn, input bit eop);
    logic [3:0] eff;
    int w;
    eff = (dq ^ (cmd[6] ? 4'hF : 4'h0)) & ~msk;
    if (r) begin
      mOwner = -1; mHeld = 0; mLowPtr = 3; mAct = 0; mPol = 0; mRot = 0;
    end else if (mOwner < 0) begin
      w = pickWinner(eff, cmd[4], mLowPtr);
      if (!cmd[2] && w >= 0) begin
        mOwner = w; mAct = w; mPol = cmd[6]; mRot = cmd[4];
      end
    end else if (!mHeld) begin
      if (hl) mHeld = 1;
      else if (dq[mOwner] == mPol) mOwner = -1;
    end else begin
      if (!hl) begin
        mOwner = -1; mHeld = 0;
      end else if (dn || eop) begin
        if (mRot) mLowPtr = mOwner;
        mOwner = -1; mHeld = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [3:0] dq, input bit hl, input logic [7:0] cmd,
                               input logic [3:0] msk, input bit dn, input bit eop);
    reset = r; dreq = dq; hlda = hl; commandReg = cmd;
    channelMask = msk; serviceDone = dn; intEop = eop;
    modelStep(r, dq, hl, cmd, msk, dn, eop);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit eHrq, input logic [3:0] eDack,
                             input logic [1:0] eAct, input bit eCa);
    total++;
    if (hrq !== eHrq || dack !== eDack || activeChannel !== eAct || channelActive !== eCa) begin
      bad++;
      $display("[TB] FAIL %s: got hrq=%0b dack=%b act=%0d ca=%0b, want hrq=%0b dack=%b act=%0d ca=%0b",
               name, hrq, dack, activeChannel, channelActive, eHrq, eDack, eAct, eCa);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] dq;
    bit         hl;
    logic [7:0] cmd;
    logic [3:0] msk;
    bit         dn;
    bit         eop;
    bit         eHrq;
    logic [3:0] eDack;
    logic [1:0] eAct;
    bit         eCa;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit rst, input logic [3:0] dq, input bit hl, input logic [7:0] cmd,
                        input logic [3:0] msk, input bit dn, input bit eop,
                        input bit eHrq, input logic [3:0] eDack, input logic [1:0] eAct, input bit eCa);
    vec_t v;
    v.rst = rst; v.dq = dq; v.hl = hl; v.cmd = cmd; v.msk = msk; v.dn = dn; v.eop = eop;
    v.eHrq = eHrq; v.eDack = eDack; v.eAct = eAct; v.eCa = eCa;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] rDreq;
    logic [3:0] rMask;
    logic [7:0] rCmd;
    bit rHlda;
    bit rRst;

    reset = 1'b1; dreq = '0; hlda = 1'b0; commandReg = '0;
    channelMask = '0; serviceDone = 1'b0; intEop = 1'b0;

    //     rst dreq    hl cmd    mask    dn eop   hrq dack    act  ca
    addVec(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0,   0, 4'b0000, 0, 0);
    addVec(0, 4'b1010, 0, 8'h00, 4'b0000, 0, 0,   1, 4'b0000, 1, 0);
    addVec(0, 4'b1010, 1, 8'h00, 4'b0000, 0, 0,   1, 4'b0010, 1, 1);
    addVec(0, 4'b1010, 1, 8'h00, 4'b0000, 1, 0,   0, 4'b0000, 1, 0);
    addVec(0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0,   0, 4'b0000, 1, 0);
    addVec(0, 4'b1110, 0, 8'h40, 4'b0000, 0, 0,   1, 4'b0000, 0, 0);
    addVec(0, 4'b1110, 1, 8'h40, 4'b0000, 0, 0,   1, 4'b0001, 0, 1);
    addVec(0, 4'b1110, 1, 8'h40, 4'b0000, 0, 1,   0, 4'b0000, 0, 0);
    addVec(0, 4'b1111, 0, 8'h40, 4'b0000, 0, 0,   0, 4'b0000, 0, 0);
    addVec(0, 4'b1000, 0, 8'h00, 4'b0000, 0, 0,   1, 4'b0000, 3, 0);
    addVec(0, 4'b1000, 1, 8'h00, 4'b0000, 0, 0,   1, 4'b1000, 3, 1);
    addVec(1, 4'b1000, 1, 8'h00, 4'b0000, 0, 0,   0, 4'b0000, 0, 0);
    addVec(0, 4'b1001, 0, 8'h10, 4'b0000, 0, 0,   1, 4'b0000, 0, 0);
    addVec(0, 4'b1001, 1, 8'h10, 4'b0000, 0, 0,   1, 4'b0001, 0, 1);
    addVec(0, 4'b1001, 1, 8'h10, 4'b0000, 1, 0,   0, 4'b0000, 0, 0);
    addVec(0, 4'b1001, 0, 8'h10, 4'b0000, 0, 0,   1, 4'b0000, 3, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].dq, vecs[i].hl, vecs[i].cmd, vecs[i].msk, vecs[i].dn, vecs[i].eop);
      checkOutput($sformatf("vec%0d", i), vecs[i].eHrq, vecs[i].eDack, vecs[i].eAct, vecs[i].eCa);
    end

    $display("[TB] rotation after ch1 service");
    applyStimulus(1, 4'b0000, 0, 8'h10, 4'b0000, 0, 0);
    applyStimulus(0, 4'b0010, 0, 8'h10, 4'b0000, 0, 0); checkOutput("rot_grant1", 1, 4'b0000, 1, 0);
    applyStimulus(0, 4'b0010, 1, 8'h10, 4'b0000, 0, 0); checkOutput("rot_dack1", 1, 4'b0010, 1, 1);
    applyStimulus(0, 4'b0000, 1, 8'h10, 4'b0000, 1, 0); checkOutput("rot_done1", 0, 4'b0000, 1, 0);
    applyStimulus(0, 4'b0111, 0, 8'h10, 4'b0000, 0, 0); checkOutput("rot_grant2", 1, 4'b0000, 2, 0);
    applyStimulus(0, 4'b0111, 1, 8'h10, 4'b0000, 0, 0); checkOutput("rot_dack2", 1, 4'b0100, 2, 1);

    $display("[TB] masked and disabled requests");
    applyStimulus(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 4'b0001, 0, 8'h00, 4'b0001, 0, 0); checkOutput("masked", 0, 4'b0000, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 4'b0001, 0, 8'h04, 4'b0000, 0, 0); checkOutput("disabled", 0, 4'b0000, 0, 0);
    end
    applyStimulus(0, 4'b0001, 0, 8'h00, 4'b0000, 0, 0); checkOutput("reenabled", 1, 4'b0000, 0, 0);

    $display("[TB] HLDA abort on ch2 keeps rotation pointer");
    applyStimulus(1, 4'b0000, 0, 8'h10, 4'b0000, 0, 0);
    applyStimulus(0, 4'b0100, 0, 8'h10, 4'b0000, 0, 0); checkOutput("abort_grant", 1, 4'b0000, 2, 0);
    applyStimulus(0, 4'b0100, 1, 8'h10, 4'b0000, 0, 0); checkOutput("abort_dack", 1, 4'b0100, 2, 1);
    applyStimulus(0, 4'b0100, 0, 8'h10, 4'b0000, 0, 0); checkOutput("abort_idle", 0, 4'b0000, 2, 0);
    applyStimulus(0, 4'b1111, 0, 8'h10, 4'b0000, 0, 0); checkOutput("abort_noRot", 1, 4'b0000, 0, 0);

    $display("[TB] request drop, frozen grant, back-to-back");
    applyStimulus(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    applyStimulus(0, 4'b0010, 0, 8'h00, 4'b0000, 0, 0); checkOutput("drop_grant", 1, 4'b0000, 1, 0);
    applyStimulus(0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0); checkOutput("drop_idle", 0, 4'b0000, 1, 0);
    applyStimulus(0, 4'b0100, 0, 8'h00, 4'b0000, 0, 0); checkOutput("frz_grant", 1, 4'b0000, 2, 0);
    applyStimulus(0, 4'b0101, 0, 8'h04, 4'b0100, 0, 0); checkOutput("frz_hold", 1, 4'b0000, 2, 0);
    applyStimulus(0, 4'b0101, 1, 8'h04, 4'b0100, 0, 0); checkOutput("frz_dack", 1, 4'b0100, 2, 1);
    applyStimulus(0, 4'b0101, 1, 8'h00, 4'b0000, 1, 0); checkOutput("b2b_idle", 0, 4'b0000, 2, 0);
    applyStimulus(0, 4'b0101, 0, 8'h00, 4'b0000, 0, 0); checkOutput("b2b_next", 1, 4'b0000, 0, 0);

    $display("[TB] combined completion and reset mid-service");
    applyStimulus(1, 4'b0000, 0, 8'h10, 4'b0000, 0, 0);
    applyStimulus(0, 4'b0001, 0, 8'h10, 4'b0000, 0, 0); checkOutput("both_grant", 1, 4'b0000, 0, 0);
    applyStimulus(0, 4'b0001, 1, 8'h10, 4'b0000, 0, 0); checkOutput("both_dack", 1, 4'b0001, 0, 1);
    applyStimulus(0, 4'b0000, 1, 8'h10, 4'b0000, 1, 1); checkOutput("both_done", 0, 4'b0000, 0, 0);
    applyStimulus(0, 4'b1111, 0, 8'h10, 4'b0000, 0, 0); checkOutput("single_rot", 1, 4'b0000, 1, 0);
    applyStimulus(0, 4'b1111, 1, 8'h10, 4'b0000, 0, 0); checkOutput("rot_dack", 1, 4'b0010, 1, 1);
    applyStimulus(0, 4'b0000, 1, 8'h10, 4'b0000, 1, 0); checkOutput("rot_done", 0, 4'b0000, 1, 0);
    applyStimulus(0, 4'b1000, 0, 8'h10, 4'b0000, 0, 0); checkOutput("rst_grant", 1, 4'b0000, 3, 0);
    applyStimulus(0, 4'b1000, 1, 8'h10, 4'b0000, 0, 0); checkOutput("rst_dack", 1, 4'b1000, 3, 1);
    applyStimulus(1, 4'b1000, 1, 8'h10, 4'b0000, 0, 0); checkOutput("rst_mid", 0, 4'b0000, 0, 0);
    applyStimulus(0, 4'b1111, 0, 8'h10, 4'b0000, 0, 0); checkOutput("rst_lowPtr", 1, 4'b0000, 0, 0);

    $display("[TB] randomized run");
    rDreq = 4'b0000; rMask = 4'b0000; rCmd = 8'h00;
    applyStimulus(1, rDreq, 0, rCmd, rMask, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rDreq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) rMask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0) begin
        rCmd = 8'h00;
        rCmd[2] = ($urandom_range(0, 5) == 0);
        rCmd[4] = $urandom_range(0, 1) != 0;
        rCmd[6] = $urandom_range(0, 1) != 0;
      end
      rHlda = (mOwner >= 0) && ($urandom_range(0, 7) != 0);
      rRst  = ($urandom_range(0, 299) == 0);
      applyStimulus(rRst, rDreq, rHlda, rCmd, rMask,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      checkOutput("random", mOwner >= 0, mHeld ? (4'b0001 << mOwner) : 4'b0000, 2'(mAct), mHeld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4, number of DMA channels; value taken from dmaRegConfigPkg.
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 DREQ  input  CHANNELS  per-channel DMA request from peripherals; polarity per commandReg bit 6.
REQ-005 HLDA  input  1  hold acknowledge from CPU.
REQ-006 commandReg  input  8  bit2 controller disable, bit4 rotating priority, bit6 DREQ active-low.
REQ-007 channelMask  input  CHANNELS  1 = channel masked, request ignored.
REQ-008 serviceDone  input  1  single-cycle pulse from timing control: current service complete.
REQ-009 intEOP  input  1  internal end-of-process; ends service like serviceDone.
REQ-010 HRQ  output  1  hold request to CPU.
REQ-011 DACK  output  CHANNELS  one-hot active-high acknowledge, consumed by datapath.
REQ-012 activeChannel  output  2  index of latched winning channel.
REQ-013 channelActive  output  1  high while in SERVICE.

Function
REQ-014 Effective request per channel SHALL be (DREQ xor commandReg[6]) and not channelMask.
REQ-015 FSM states SHALL be IDLE, WAIT_HLDA, SERVICE; all outputs registered.
REQ-016 IDLE: if commandReg[2]=0 and any effective request, latch winner into activeChannel, go WAIT_HLDA; HRQ high one cycle after the sampled request edge.
REQ-017 IDLE with commandReg[2]=1 SHALL remain IDLE regardless of requests.
REQ-018 WAIT_HLDA: HRQ held high; HLDA=1 -> SERVICE, DACK[activeChannel]=1 on next edge.
REQ-019 WAIT_HLDA: if latched channel's effective request drops before HLDA, return IDLE, HRQ low next edge; winner never re-arbitrated while in WAIT_HLDA.
REQ-020 SERVICE: HRQ and exactly one DACK bit high; serviceDone or intEOP -> IDLE, HRQ, DACK, channelActive low next edge.
REQ-021 SERVICE: HLDA falling -> abort to IDLE next edge, no priority rotation.
REQ-022 commandReg or channelMask changes during WAIT_HLDA/SERVICE SHALL not affect current grant; take effect from IDLE.
REQ-023 Fixed priority (commandReg[4]=0): channel 0 highest, 3 lowest.
REQ-024 Rotating priority: 2-bit pointer lowPtr marks lowest channel; highest = lowPtr+1 mod 4 (wrap 3->0); on normal service completion lowPtr <= activeChannel.
REQ-025 Simultaneous serviceDone and intEOP SHALL be treated as one completion (single rotation).
REQ-026 IDLE-to-HRQ minimum latency 1 cycle; back-to-back services SHALL pass through IDLE for at least one cycle with HRQ low.

Reset
REQ-027 RESET SHALL force state IDLE, HRQ=0, DACK=0, activeChannel=0, channelActive=0, lowPtr=3, in any state including mid-service.

Structure
REQ-028 CHANNELS, state enum type, and commandReg bit-position constants SHALL live in dmaRegConfigPkg.
REQ-029 Winner selection SHALL be one combinational sub-module dma_priority_encoder (inputs: requests, lowPtr, rotate enable; outputs: valid, index).

Verification
REQ-030 DREQ=4'b1010, mask 0, fixed -> HRQ=1 next cycle; HLDA=1 -> DACK=4'b0010, activeChannel=1.
REQ-031 Rotating, ch1 served then DREQ=4'b0011 -> ch0 not preferred; winner ch0 only after ch2/ch3 absent: expect lowPtr=1, highest=2, DACK=4'b0001 since ch2/3 idle... bench checks DREQ=4'b0111 after ch1 service -> DACK=4'b0100.
REQ-032 commandReg[6]=1, DREQ=4'b1110 -> ch0 requests, DACK=4'b0001 after HLDA.
REQ-033 DREQ=4'b0001 with channelMask=4'b0001 or commandReg[2]=1 -> HRQ stays 0 for 10 cycles.
REQ-034 RESET asserted in SERVICE with DACK=4'b1000 -> next edge HRQ=0, DACK=0, lowPtr=3.
REQ-035 HLDA dropped in SERVICE on ch2 (rotating) -> IDLE next edge, lowPtr unchanged.
